// File: rtl/obu_bit_aligner.sv
// rtl/obu_bit_aligner.sv - left-justified bit shift buffer presenting an MSB-first window to the OBU parsers
// Optional feature macro OBU_BIT_POS_EN adds bit_pos/byte_aligned consumption tracking.
module obu_bit_aligner #(
  parameter int PARSER_DATA_WIDTH = 32,
  parameter int PAD_LEN_WIDTH     = 6,
  parameter int IN_WIDTH          = 32,
  parameter int BUF_WIDTH         = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [IN_WIDTH-1:0]          in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [PARSER_DATA_WIDTH-1:0] data_out,
  output logic                         avail,
  input  logic                         pad,
  input  logic [PAD_LEN_WIDTH-1:0]     pad_len,
  input  logic                         pop,
  output logic [6:0]                   bits_left,
  output logic                         stream_end,
  output logic                         proto_err
`ifdef OBU_BIT_POS_EN
  ,
  output logic [31:0]                  bit_pos,
  output logic                         byte_aligned
`endif
);

  localparam logic [6:0] PDW_W  = 7'(PARSER_DATA_WIDTH);
  localparam logic [6:0] IN_W   = 7'(IN_WIDTH);
  localparam logic [6:0] ROOM_W = 7'(BUF_WIDTH - IN_WIDTH);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_READY,
    ST_DRAIN,
    ST_END
  } state_t;

  state_t               state;
  logic [BUF_WIDTH-1:0] shift_q;
  logic [BUF_WIDTH-1:0] shift_d;
  logic [6:0]           left_d;
  logic [6:0]           c_req;
  logic [6:0]           c_amt;
  logic [6:0]           rem;
  logic                 last_seen;
  logic                 last_d;
  logic                 err_d;
  logic                 accept;

  // State is a pure function of the registered fill level and last flag.
  always_comb begin
    state = ST_FILL;
    if (bits_left >= PDW_W)
      state = ST_READY;
    else if (last_seen && (bits_left == 7'd0))
      state = ST_END;
    else if (last_seen)
      state = ST_DRAIN;
  end

  assign avail      = (state == ST_READY) || (state == ST_DRAIN);
  assign stream_end = (state == ST_END);
  assign in_ready   = !last_seen && (bits_left <= ROOM_W);
  assign data_out   = shift_q[BUF_WIDTH-1 -: PARSER_DATA_WIDTH];
  assign accept     = in_valid && in_ready;

  always_comb begin
    c_req = 7'd0;
    err_d = proto_err;
    if (avail) begin
      if (pop) begin
        c_req = PDW_W;
        if (pad)
          err_d = 1'b1;
      end else if (pad) begin
        if (7'(pad_len) > PDW_W) begin
          c_req = PDW_W;
          err_d = 1'b1;
        end else begin
          c_req = 7'(pad_len);
        end
      end
    end
    // Over-consumption while draining empties the buffer rather than underflowing.
    c_amt = c_req;
    if (c_req > bits_left) begin
      c_amt = bits_left;
      err_d = 1'b1;
    end
    rem     = bits_left - c_amt;
    shift_d = shift_q << c_amt;
    left_d  = rem;
    last_d  = last_seen;
    if (accept) begin
      shift_d = shift_d | ({in_data, {(BUF_WIDTH-IN_WIDTH){1'b0}}} >> rem);
      left_d  = rem + IN_W;
      if (in_last)
        last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bits_left <= 7'd0;
      last_seen <= 1'b0;
      proto_err <= 1'b0;
    end else if (flush) begin
      shift_q   <= '0;
      bits_left <= 7'd0;
      last_seen <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bits_left <= left_d;
      last_seen <= last_d;
      proto_err <= err_d;
    end
  end

`ifdef OBU_BIT_POS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bit_pos <= 32'd0;
    else if (flush)
      bit_pos <= 32'd0;
    else
      bit_pos <= bit_pos + 32'(c_amt);
  end

  assign byte_aligned = (bit_pos[2:0] == 3'd0);
`endif

endmodule
